imm_encoder: RTL and testbench

Sequenced RISC-V instruction emitter: turns one high-level request into one or two encoded RV32I instruction words. Supported requests are load-immediate (LUI+ADDI), store-word (SW) and jump-and-link (JAL). It is the encode-side counterpart of the core's immediate decoder: it scatters immediates into U, I, S and J formats. It feeds the debug program-buffer / instruction-injection path over a valid/ready stream.

---
 rtl/immenc_pkg.sv | 33 +++
 rtl/insn_pack.sv | 27 ++
 rtl/imm_encoder.sv | 158 +++++++++++++++
 tb/tb_imm_encoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/immenc_pkg.sv
// Shared encodings for the immediate encoder: RV32I opcodes/funct3, request ops,
// packer format select and sequencer states.
package immenc_pkg;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SW   = 3'b010;

   typedef enum logic [1:0] {
      OP_LI   = 2'd0,
      OP_SW   = 2'd1,
      OP_JAL  = 2'd2,
      OP_RSVD = 2'd3
   } reqOpT;

   typedef enum logic [1:0] {
      FMT_U = 2'd0,
      FMT_I = 2'd1,
      FMT_S = 2'd2,
      FMT_J = 2'd3
   } fmtT;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT1 = 2'd1,
      ST_EMIT2 = 2'd2
   } stateT;

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I format packer: scatters a 32-bit immediate into the
// U, I, S or J layout around the given register fields and opcode.
module insn_pack
   import immenc_pkg::*;
(
   input  fmtT         fmt,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  opcode,
   input  logic [31:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = 32'h0;
      unique case (fmt)
         FMT_U: word = {imm[31:12], rd, opcode};
         FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: word = 32'h0;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Sequenced RV32I emitter: one request in, LUI+ADDI / SW / JAL words out.
// Optional IMMENC_SHORT_EN collapses small LI constants into a single ADDI.
module imm_encoder
   import immenc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_value,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic        insn_last,
   output logic        err
);

   stateT       state;
   stateT       nextState;
   reqOpT       opQ;
   logic [4:0]  rdQ;
   logic [4:0]  rs1Q;
   logic [4:0]  rs2Q;
   logic [31:0] valueQ;
   logic        shortQ;

   logic        accept;
   logic        reject;
   logic        shortReq;
   logic        transfer;
   logic        smallImm;
   logic [19:0] hiImm;

   fmtT         fmt;
   logic [4:0]  packRs1;
   logic [2:0]  packF3;
   logic [6:0]  packOpc;
   logic [31:0] packImm;
   logic [31:0] packedWord;
   logic        lastWord;

   assign accept   = req_valid && req_ready;
   assign transfer = insn_valid && insn_ready;
   assign smallImm = (req_value[31:11] == '0) || (req_value[31:11] == '1);

   // Legality is judged on the raw request so a rejection never leaves IDLE.
   always_comb begin
      reject = 1'b0;
      unique case (reqOpT'(req_op))
         OP_SW:   reject = !smallImm;
         OP_JAL:  reject = req_value[0] ||
                           !((req_value[31:20] == '0) || (req_value[31:20] == '1));
         OP_RSVD: reject = 1'b1;
         default: reject = 1'b0;
      endcase
   end

`ifdef IMMENC_SHORT_EN
   assign shortReq = (reqOpT'(req_op) == OP_LI) && smallImm;
`else
   assign shortReq = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         opQ    <= OP_LI;
         rdQ    <= '0;
         rs1Q   <= '0;
         rs2Q   <= '0;
         valueQ <= '0;
         shortQ <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= nextState;
         err   <= accept && reject;
         if (accept) begin
            opQ    <= reqOpT'(req_op);
            rdQ    <= req_rd;
            rs1Q   <= req_rs1;
            rs2Q   <= req_rs2;
            valueQ <= req_value;
            shortQ <= shortReq;
         end
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE:  if (accept && !reject) nextState = ST_EMIT1;
         ST_EMIT1: if (transfer)
                      nextState = (opQ == OP_LI && !shortQ) ? ST_EMIT2 : ST_IDLE;
         ST_EMIT2: if (transfer) nextState = ST_IDLE;
         default:  nextState = ST_IDLE;
      endcase
   end

   // The ADDI sign-extends its low 12 bits, so LUI must pre-compensate by value[11].
   assign hiImm = valueQ[31:12] + {19'b0, valueQ[11]};

   always_comb begin
      fmt      = FMT_I;
      packRs1  = rdQ;
      packF3   = F3_ADDI;
      packOpc  = OPC_OPIMM;
      packImm  = valueQ;
      lastWord = 1'b1;
      if (state == ST_EMIT1) begin
         unique case (opQ)
            OP_LI: begin
               if (shortQ) begin
                  packRs1 = 5'd0;
               end else begin
                  fmt      = FMT_U;
                  packOpc  = OPC_LUI;
                  packImm  = {hiImm, 12'h000};
                  lastWord = 1'b0;
               end
            end
            OP_SW: begin
               fmt     = FMT_S;
               packRs1 = rs1Q;
               packF3  = F3_SW;
               packOpc = OPC_STORE;
            end
            OP_JAL: begin
               fmt     = FMT_J;
               packOpc = OPC_JAL;
            end
            default: begin
               fmt     = FMT_I;
            end
         endcase
      end
   end

   insn_pack uPack (
      .fmt    (fmt),
      .rd     (rdQ),
      .rs1    (packRs1),
      .rs2    (rs2Q),
      .funct3 (packF3),
      .opcode (packOpc),
      .imm    (packImm),
      .word   (packedWord)
   );

   assign req_ready  = (state == ST_IDLE);
   assign insn_valid = (state != ST_IDLE);
   assign insn       = insn_valid ? packedWord : 32'h0;
   assign insn_last  = insn_valid && lastWord;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; expected words are hand-encoded
// RV32I instructions, with the LI short form chosen by IMMENC_SHORT_EN.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [4:0]  req_rs1 = 5'd0;
   logic [4:0]  req_rs2 = 5'd0;
   logic [31:0] req_value = 32'h0;
   logic        insn_valid;
   logic        insn_ready = 1'b1;
   logic [31:0] insn;
   logic        insn_last;
   logic        err;

   int checks = 0;
   int errors = 0;

   imm_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_value  (req_value),
      .insn_valid (insn_valid),
      .insn_ready (insn_ready),
      .insn       (insn),
      .insn_last  (insn_last),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one request for a single accept edge, then withdraws it.
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] value);
      req_op    = op;
      req_rd    = rd;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_value = value;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic checkWord(input string tag, input logic [31:0] word, input logic last);
      checkOutput({tag, "_valid"}, {31'b0, insn_valid}, 32'd1);
      checkOutput({tag, "_insn"}, insn, word);
      checkOutput({tag, "_last"}, {31'b0, insn_last}, {31'b0, last});
      checkOutput({tag, "_rdy"}, {31'b0, req_ready}, 32'd0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, {31'b0, insn_valid}, 32'd0);
      checkOutput({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
   endtask

   task automatic checkReject(input string tag);
      checkOutput({tag, "_err"}, {31'b0, err}, 32'd1);
      checkIdle(tag);
      tick();
      checkOutput({tag, "_errclr"}, {31'b0, err}, 32'd0);
      checkIdle({tag, "_after"});
   endtask

   initial begin
      tick();
      checkOutput("rst_rdy", {31'b0, req_ready}, 32'd1);
      checkOutput("rst_valid", {31'b0, insn_valid}, 32'd0);
      checkOutput("rst_insn", insn, 32'h0);
      checkOutput("rst_last", {31'b0, insn_last}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] LI x5, 0x12345FFF");
      applyStimulus(2'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      checkWord("li_w1", 32'h123462B7, 1'b0);
      tick();
      checkWord("li_w2", 32'hFFF28293, 1'b1);
      tick();
      checkIdle("li_done");

      $display("[TB] LI x1, 0x7FFFF800 (hi wraps to bit 31)");
      applyStimulus(2'd0, 5'd1, 5'd0, 5'd0, 32'h7FFFF800);
      checkWord("lib_w1", 32'h800000B7, 1'b0);
      tick();
      checkWord("lib_w2", 32'h80008093, 1'b1);
      tick();

      $display("[TB] SW x6, 8(x2)");
      applyStimulus(2'd1, 5'd0, 5'd2, 5'd6, 32'h8);
      checkWord("sw", 32'h00612423, 1'b1);
      tick();
      checkIdle("sw_done");

      $display("[TB] JAL x1, +16 and JAL x0, -1MiB");
      applyStimulus(2'd2, 5'd1, 5'd0, 5'd0, 32'h10);
      checkWord("jal", 32'h010000EF, 1'b1);
      tick();
      applyStimulus(2'd2, 5'd0, 5'd0, 5'd0, 32'hFFF00000);
      checkWord("jal_neg", 32'h8000006F, 1'b1);
      tick();
      checkIdle("jal_done");

      $display("[TB] LI x10, 5");
      applyStimulus(2'd0, 5'd10, 5'd0, 5'd0, 32'h5);
`ifdef IMMENC_SHORT_EN
      checkWord("lis_w1", 32'h00500513, 1'b1);
`else
      checkWord("lis_w1", 32'h00000537, 1'b0);
      tick();
      checkWord("lis_w2", 32'h00550513, 1'b1);
`endif
      tick();
      checkIdle("lis_done");

      $display("[TB] backpressure on LI word 1");
      insn_ready = 1'b0;
      applyStimulus(2'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      for (int i = 0; i < 3; i++) begin
         checkWord("bp_hold", 32'h123462B7, 1'b0);
         tick();
      end
      checkWord("bp_hold_end", 32'h123462B7, 1'b0);
      insn_ready = 1'b1;
      tick();
      checkWord("bp_w2", 32'hFFF28293, 1'b1);
      tick();
      checkIdle("bp_done");

      $display("[TB] rejections");
      applyStimulus(2'd2, 5'd1, 5'd0, 5'd0, 32'h3);
      checkReject("rej_jal_odd");
      applyStimulus(2'd3, 5'd1, 5'd0, 5'd0, 32'h0);
      checkReject("rej_op3");
      applyStimulus(2'd1, 5'd0, 5'd2, 5'd6, 32'h800);
      checkReject("rej_sw_range");

      $display("[TB] reset during LI word 2");
      applyStimulus(2'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      tick();
      checkWord("mid_w2", 32'hFFF28293, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", {31'b0, insn_valid}, 32'd0);
      checkOutput("mid_rst_insn", insn, 32'h0);
      checkOutput("mid_rst_rdy", {31'b0, req_ready}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(2'd1, 5'd0, 5'd2, 5'd6, 32'h8);
      checkWord("post_rst_sw", 32'h00612423, 1'b1);
      tick();
      checkIdle("post_rst_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
